// File: rtl/rails_seq_if.sv
// ---------------------------------------------------------------------------
// rails_seq_if
// Groups the rails_seq input stream, operation stream and result strobe.
//
// Signals:
//   in_valid  pattern word present            (master -> slave)
//   data      4-bit pattern word               (master -> slave)
//   in_ready  sequencer accepts a word         (slave  -> master)
//   op_ready  station accepts current op       (master -> slave)
//   op_valid  operation presented              (slave  -> master)
//   op_push   1 = push into station, 0 = pop   (slave  -> master)
//   op_car    car number of the operation      (slave  -> master)
//   valid     one-cycle result strobe          (slave  -> master)
//   result    1 = order achievable             (slave  -> master)
//
// The slave modport is the sequencer; the master modport is whatever feeds
// patterns and consumes operations.
// ---------------------------------------------------------------------------
interface rails_seq_if;
   logic       in_valid;
   logic [3:0] data;
   logic       in_ready;
   logic       op_ready;
   logic       op_valid;
   logic       op_push;
   logic [3:0] op_car;
   logic       valid;
   logic       result;

   modport master (
      output in_valid, data, op_ready,
      input  in_ready, op_valid, op_push, op_car, valid, result
   );

   modport slave (
      input  in_valid, data, op_ready,
      output in_ready, op_valid, op_push, op_car, valid, result
   );
endinterface

// File: rtl/rails_seq.sv
// ---------------------------------------------------------------------------
// rails_seq
// Railway station stack sequencer. Cars 1..N arrive in ascending order and
// may be parked on a single stack siding; the block decides whether a
// requested departure order can be produced and emits the push/pop operations
// that realise it.
//
// Ports:
//   clk    single clock, all state on the rising edge
//   reset  asynchronous, active-high reset
//   bus    rails_seq_if.slave:
//            in_valid/data/in_ready   pattern input (N, then N order values)
//            op_valid/op_ready        operation handshake
//            op_push/op_car           operation kind and car number
//            valid/result             one-cycle result strobe
//
// Configuration:
//   RAILS_SEQ_EARLY_ABORT_EN  when defined, RUN stops as soon as the wanted
//                             car has already arrived but is not on top of
//                             the stack, instead of pushing all remaining
//                             cars first. The result value is the same in
//                             both builds; only the operation count differs.
// ---------------------------------------------------------------------------
module rails_seq (
   input logic        clk,
   input logic        reset,
   rails_seq_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t     state;
   logic [3:0] n_cnt;
   logic [3:0] idx;
   logic [3:0] sp;
   logic [3:0] tgt;
   logic [4:0] next_in;
   logic [3:0] order_mem [15];
   logic [3:0] stack_mem [15];

   logic       op_valid_q;
   logic       op_push_q;
   logic [3:0] op_car_q;
   logic       valid_q;
   logic       result_q;

   logic       hs;
   logic [3:0] eff_sp;
   logic [3:0] eff_tgt;
   logic [3:0] eff_top;
   logic [4:0] eff_next;
   logic [3:0] want;
   logic       do_pop;
   logic       do_push;
   logic       done_ok;
   logic       done_fail;

`ifdef RAILS_SEQ_EARLY_ABORT_EN
   logic [3:0] first_want;
`endif

   assign bus.in_ready = (state == IDLE) || (state == LOAD);
   assign bus.op_valid = op_valid_q;
   assign bus.op_push  = op_push_q;
   assign bus.op_car   = op_car_q;
   assign bus.valid    = valid_q;
   assign bus.result   = result_q;

   // The committed stack/tgt/next_in only change when an op handshakes, but
   // the next op must be chosen in that same cycle to keep one op per cycle.
   // So the decision works on "effective" values: the registered state with
   // the effect of the op completing this cycle already applied.
   always_comb begin
      hs       = op_valid_q & bus.op_ready;
      eff_sp   = sp;
      eff_tgt  = tgt;
      eff_next = next_in;
      eff_top  = (sp != 4'd0) ? stack_mem[sp - 4'd1] : 4'd0;
      if (hs) begin
         if (op_push_q) begin
            eff_sp   = sp + 4'd1;
            eff_next = next_in + 5'd1;
            eff_top  = op_car_q;
         end else begin
            eff_sp   = sp - 4'd1;
            eff_tgt  = tgt + 4'd1;
            eff_top  = (sp >= 4'd2) ? stack_mem[sp - 4'd2] : 4'd0;
         end
      end
      want = (eff_tgt < 4'd15) ? order_mem[eff_tgt] : 4'd0;

      done_ok   = 1'b0;
      done_fail = 1'b0;
      do_pop    = 1'b0;
      do_push   = 1'b0;
      if (eff_tgt == n_cnt) begin
         done_ok = 1'b1;
      end else if ((eff_sp != 4'd0) && (eff_top == want)) begin
         do_pop = 1'b1;
`ifdef RAILS_SEQ_EARLY_ABORT_EN
      end else if ({1'b0, want} < eff_next) begin
         done_fail = 1'b1;
`endif
      end else if (eff_next <= {1'b0, n_cnt}) begin
         do_push = 1'b1;
      end else begin
         done_fail = 1'b1;
      end
   end

`ifdef RAILS_SEQ_EARLY_ABORT_EN
   // On the last LOAD word the first order value may be the word arriving
   // right now, so it is taken from the bus when N = 1.
   always_comb begin
      first_want = (idx == 4'd0) ? bus.data : order_mem[0];
   end
`endif

   // Order buffer and stack storage. These are plain memories; the stack
   // pointer and load index (which are reset) decide what is meaningful.
   always_ff @(posedge clk) begin
      if ((state == LOAD) && bus.in_valid) begin
         order_mem[idx] <= bus.data;
      end
      if ((state == RUN) && hs && op_push_q) begin
         stack_mem[sp] <= op_car_q;
      end
   end

   // Main sequencer. All outputs are registered here. Entering DONE raises
   // valid for exactly the one cycle spent in DONE. The first op of a pattern
   // is issued together with the last LOAD word so it appears the next cycle;
   // with the stack empty that op is always a push of car 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         n_cnt      <= 4'd0;
         idx        <= 4'd0;
         sp         <= 4'd0;
         tgt        <= 4'd0;
         next_in    <= 5'd0;
         op_valid_q <= 1'b0;
         op_push_q  <= 1'b0;
         op_car_q   <= 4'd0;
         valid_q    <= 1'b0;
         result_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  n_cnt <= bus.data;
                  idx   <= 4'd0;
                  if (bus.data == 4'd0) begin
                     state    <= DONE;
                     valid_q  <= 1'b1;
                     result_q <= 1'b1;
                  end else begin
                     state <= LOAD;
                  end
               end
            end

            LOAD: begin
               if (bus.in_valid) begin
                  idx <= idx + 4'd1;
                  if (idx == (n_cnt - 4'd1)) begin
                     sp      <= 4'd0;
                     tgt     <= 4'd0;
                     next_in <= 5'd1;
`ifdef RAILS_SEQ_EARLY_ABORT_EN
                     if (first_want == 4'd0) begin
                        state    <= DONE;
                        valid_q  <= 1'b1;
                        result_q <= 1'b0;
                     end else begin
                        state      <= RUN;
                        op_valid_q <= 1'b1;
                        op_push_q  <= 1'b1;
                        op_car_q   <= 4'd1;
                     end
`else
                     state      <= RUN;
                     op_valid_q <= 1'b1;
                     op_push_q  <= 1'b1;
                     op_car_q   <= 4'd1;
`endif
                  end
               end
            end

            RUN: begin
               if (!op_valid_q || hs) begin
                  sp      <= eff_sp;
                  tgt     <= eff_tgt;
                  next_in <= eff_next;
                  if (done_ok || done_fail) begin
                     state      <= DONE;
                     op_valid_q <= 1'b0;
                     op_push_q  <= 1'b0;
                     op_car_q   <= 4'd0;
                     valid_q    <= 1'b1;
                     result_q   <= done_ok;
                  end else if (do_pop) begin
                     op_valid_q <= 1'b1;
                     op_push_q  <= 1'b0;
                     op_car_q   <= eff_top;
                  end else if (do_push) begin
                     op_valid_q <= 1'b1;
                     op_push_q  <= 1'b1;
                     op_car_q   <= eff_next[3:0];
                  end
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
